// File: rtl/mem_responder.sv
// mem_responder: memory-mapped responder for a simple initiator bus.
//   Decodes a 16-bit word address space into an external synchronous RAM
//   (0x0000-0xFEFF, 1-cycle read latency) and a small MMIO block:
//     0xFF00 LED register (R/W), 0xFF01 event FIFO pop (R),
//     0xFF02 status {11'b0, overflow, empty, count[2:0]} (R),
//     0xFF03 free-running cycle counter (R, only with MEM_RESPONDER_CYCLECNT_EN).
//   Writes above 0xFF00 are ignored, and reads of unmapped MMIO return 0.
//   Push-button rising edges are captured into a 4-entry event FIFO.
// Ports:
//   clk, reset (async, active-low)
//   memread, memwrite, addr[15:0], wdata[15:0]   initiator request (held until ready)
//   rdata[15:0], ready                           one-cycle completion strobe + read data
//   ram_addr[15:0], ram_we, ram_wdata[15:0], ram_rdata[15:0]   synchronous RAM port
//   btn[3:0]                                     raw asynchronous push-buttons
//   led[15:0]                                    LED register contents
// Build option: define MEM_RESPONDER_CYCLECNT_EN to include the cycle counter.
module mem_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [15:0] ram_wdata,
  input  logic [15:0] ram_rdata,
  input  logic [3:0]  btn,
  output logic [15:0] led
);

  localparam logic [15:0] MMIO_BASE = 16'hFF00;
  localparam logic [15:0] LED_ADDR  = 16'hFF00;
  localparam logic [15:0] POP_ADDR  = 16'hFF01;
  localparam logic [15:0] STAT_ADDR = 16'hFF02;
  localparam logic [15:0] CNT_ADDR  = 16'hFF03;

  typedef enum logic [1:0] {IDLE, RAM_RD, RESP} state_t;
  state_t state;

  logic is_ram;
  logic acc_wr;
  logic acc_rd;
  assign is_ram = (addr < MMIO_BASE);
  assign acc_wr = (state == IDLE) && memwrite;
  // memwrite wins when both requests are high
  assign acc_rd = (state == IDLE) && memread && !memwrite;

  // RAM port is driven straight from the request so the RAM sees the
  // address/write in the accept cycle; reset forces it quiet.
  assign ram_we    = reset && acc_wr && is_ram;
  assign ram_addr  = reset ? addr  : 16'h0000;
  assign ram_wdata = reset ? wdata : 16'h0000;

  // ---- button synchroniser (p0, p1) and edge-history flop (p2) ----
  logic [3:0] btn_p0, btn_p1, btn_p2;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_p0 <= 4'h0;
      btn_p1 <= 4'h0;
      btn_p2 <= 4'h0;
    end else begin
      btn_p0 <= btn;
      btn_p1 <= btn_p0;
      btn_p2 <= btn_p1;
    end
  end

  logic [3:0] rise;
  logic       push;
  assign rise = btn_p1 & ~btn_p2;
  assign push = |rise;

  // ---- event FIFO ----
  logic [3:0] fifo_mem [4];
  logic [1:0] wp, rp;
  logic [2:0] count;
  logic       ovf;
  logic       empty, full;
  logic       pop_req, stat_rd, do_pop, do_push, ovf_set;

  assign empty   = (count == 3'd0);
  assign full    = (count == 3'd4);
  assign pop_req = acc_rd && (addr == POP_ADDR);
  assign stat_rd = acc_rd && (addr == STAT_ADDR);
  assign do_pop  = pop_req && !empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the push
  assign do_push = push && (!full || do_pop);
  assign ovf_set = push && full && !do_pop;

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wp] <= rise;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= 2'd0;
      rp    <= 2'd0;
      count <= 3'd0;
      ovf   <= 1'b0;
    end else begin
      if (do_push) wp <= wp + 2'd1;
      if (do_pop)  rp <= rp + 2'd1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      // a status read clears the sticky flag unless a new overflow lands now
      ovf <= ovf_set | (ovf & ~stat_rd);
    end
  end

`ifdef MEM_RESPONDER_CYCLECNT_EN
  logic [15:0] cyc_cnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cyc_cnt <= 16'h0000;
    else        cyc_cnt <= cyc_cnt + 16'h0001;
  end
`endif

  // ---- MMIO read mux ----
  logic [15:0] mmio_rd;
  always_comb begin
    mmio_rd = 16'h0000;
    case (addr)
      LED_ADDR:  mmio_rd = led;
      POP_ADDR:  mmio_rd = empty ? 16'h0000 : {12'h000, fifo_mem[rp]};
      STAT_ADDR: mmio_rd = {11'b0, ovf, empty, count};
`ifdef MEM_RESPONDER_CYCLECNT_EN
      CNT_ADDR:  mmio_rd = cyc_cnt;
`else
      CNT_ADDR:  mmio_rd = 16'h0000;
`endif
      default:   mmio_rd = 16'h0000;
    endcase
  end

  // ---- transaction FSM ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ready <= 1'b0;
      rdata <= 16'h0000;
      led   <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          if (memwrite) begin
            if (addr == LED_ADDR) led <= wdata;
            ready <= 1'b1;
            state <= RESP;
          end else if (memread) begin
            if (is_ram) begin
              state <= RAM_RD;
            end else begin
              rdata <= mmio_rd;
              ready <= 1'b1;
              state <= RESP;
            end
          end
        end
        RAM_RD: begin
          rdata <= ram_rdata;
          ready <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          ready <= 1'b0;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: external synchronous RAM model,
// behavioural reference (RAM contents, LED, event queue, overflow flag),
// directed scenarios plus a randomized transaction loop.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memread = 1'b0;
  logic        memwrite = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic [15:0] wdata = 16'h0000;
  logic [15:0] rdata;
  logic        ready;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic [3:0]  btn = 4'h0;
  logic [15:0] led;

  mem_responder dut (
    .clk(clk), .reset(reset), .memread(memread), .memwrite(memwrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .btn(btn), .led(led)
  );

  always #5 clk = ~clk;

  // synchronous RAM, 1-cycle read latency
  logic [15:0] ram [0:65535];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int bad_we = 0;
  always @(negedge clk) begin
    if (reset && ram_we && ram_addr >= 16'hFF00) bad_we++;
  end

  // reference model
  logic [15:0] ref_ram [logic [15:0]];
  logic [15:0] ref_led = 16'h0000;
  logic [3:0]  ref_q [$];
  bit          ref_ovf = 1'b0;
  logic [3:0]  btn_cur = 4'h0;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives a request at the current negedge, waits (bounded) for ready,
  // then confirms ready drops after one cycle.
  task automatic txn(input logic rd, input logic wr, input logic [15:0] a,
                     input logic [15:0] d, output logic [15:0] data, output int lat);
    memread = rd; memwrite = wr; addr = a; wdata = d;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ready && lat < 8);
    data = rdata;
    memread = 1'b0; memwrite = 1'b0;
    @(negedge clk);
    chk("ready_one_cycle", {31'b0, ready}, 32'd0);
  endtask

  function automatic logic [15:0] status_model();
    return {11'b0, ref_ovf, (ref_q.size() == 0), 3'(ref_q.size())};
  endfunction

  task automatic op_write(input logic [15:0] a, input logic [15:0] d, input logic both);
    logic [15:0] data;
    int lat;
    txn(both, 1'b1, a, d, data, lat);
    chk("wr_lat", lat, 32'd1);
    if (a < 16'hFF00) ref_ram[a] = d;
    else if (a == 16'hFF00) ref_led = d;
    chk("led", {16'h0, led}, {16'h0, ref_led});
  endtask

  task automatic op_read(input logic [15:0] a, input string tag);
    logic [15:0] data, exp;
    int lat, exp_lat;
    exp_lat = (a < 16'hFF00) ? 2 : 1;
    exp = 16'h0000;
    if (a < 16'hFF00) exp = ref_ram.exists(a) ? ref_ram[a] : 16'h0000;
    else if (a == 16'hFF00) exp = ref_led;
    else if (a == 16'hFF01) begin
      if (ref_q.size() != 0) exp = {12'h000, ref_q.pop_front()};
    end else if (a == 16'hFF02) begin
      exp = status_model();
      ref_ovf = 1'b0;
    end
    txn(1'b1, 1'b0, a, 16'h0000, data, lat);
    chk({tag, "_lat"}, lat, exp_lat);
    chk(tag, {16'h0, data}, {16'h0, exp});
  endtask

  task automatic op_btn(input logic [3:0] nb);
    logic [3:0] r;
    r = nb & ~btn_cur;
    btn = nb;
    btn_cur = nb;
    if (r != 4'h0) begin
      if (ref_q.size() < 4) ref_q.push_back(r);
      else ref_ovf = 1'b1;
    end
    repeat (4) @(negedge clk);
  endtask

  logic [15:0] pool [8] = '{16'h0000, 16'h0010, 16'h0020, 16'h0100,
                            16'h7FFF, 16'h8000, 16'hABCD, 16'hFEFF};

  initial begin
    logic [15:0] v1, v2, dd;
    int lat;

    // reset state, with a request pending on the bus
    addr = 16'hBEEF; wdata = 16'h1234; memwrite = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_rdata", {16'h0, rdata}, 32'h0);
    chk("rst_led", {16'h0, led}, 32'h0);
    chk("rst_ram_we", {31'b0, ram_we}, 32'd0);
    chk("rst_ram_addr", {16'h0, ram_addr}, 32'h0);
    chk("rst_ram_wdata", {16'h0, ram_wdata}, 32'h0);
    memwrite = 1'b0; addr = 16'h0000; wdata = 16'h0000;
    reset = 1'b1;
    @(negedge clk);
    op_read(16'hFF02, "status_after_reset");

    // write then read RAM
    op_write(16'h0010, 16'h1234, 1'b0);
    op_read(16'h0010, "ram_rd_0010");
    // LED register
    op_write(16'hFF00, 16'hA5A5, 1'b0);
    chk("led_a5a5", {16'h0, led}, 32'hA5A5);
    op_read(16'hFF00, "led_rd");
    // simultaneous read+write is a write
    op_write(16'h0020, 16'h00FF, 1'b1);
    op_read(16'h0020, "ram_rd_0020");
    // ignored writes, unmapped reads, top RAM word
    op_write(16'hFF01, 16'h5555, 1'b0);
    op_write(16'hFFFF, 16'h6666, 1'b0);
    op_read(16'hFF04, "unmapped_ff04");
    op_read(16'hFFFF, "unmapped_ffff");
    op_write(16'hFEFF, 16'hBEEF, 1'b0);
    op_read(16'hFEFF, "ram_rd_feff");

    // button events bit0 then bit2, three pops, status
    op_btn(4'h1); op_btn(4'h0); op_btn(4'h4); op_btn(4'h0);
    op_read(16'hFF01, "pop1");
    op_read(16'hFF01, "pop2");
    op_read(16'hFF01, "pop_empty");
    op_read(16'hFF02, "status_empty");

    // overflow: 5 events with no pop
    for (int i = 0; i < 5; i++) begin
      op_btn(4'h1); op_btn(4'h0);
    end
    op_read(16'hFF02, "status_ovf");
    op_read(16'hFF02, "status_ovf_cleared");

    // push and pop in the same cycle while full
    btn = 4'h2;
    @(negedge clk); @(negedge clk);
    txn(1'b1, 1'b0, 16'hFF01, 16'h0000, dd, lat);
    chk("pop_full_lat", lat, 32'd1);
    chk("pop_full", {16'h0, dd}, {28'h0, ref_q.pop_front()});
    btn_cur = 4'h2;
    ref_q.push_back(4'h2);
    op_read(16'hFF02, "status_pushpop_full");
    op_btn(4'h0);
    for (int i = 0; i < 5; i++) op_read(16'hFF01, "drain");

    // randomized traffic
    for (int i = 0; i < 8; i++) op_write(pool[i], 16'($urandom), 1'b0);
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 7))
        0: op_write(pool[$urandom_range(0, 7)], 16'($urandom), 1'($urandom_range(0, 1)));
        1, 2: op_read(pool[$urandom_range(0, 7)], "rnd_ram_rd");
        3: op_write(16'hFF00, 16'($urandom), 1'($urandom_range(0, 1)));
        4: op_read(16'hFF00 + 16'($urandom_range(0, 2)), "rnd_mmio_rd");
        5: op_btn(4'($urandom_range(0, 15)));
        6: op_write(16'hFF01 + 16'($urandom_range(0, 254)), 16'($urandom), 1'($urandom_range(0, 1)));
        default: op_read(16'hFF04 + 16'($urandom_range(0, 251)), "rnd_unmapped");
      endcase
    end

    // reset while a RAM read is in flight
    op_btn(4'h0);
    op_write(16'h0030, 16'hCAFE, 1'b0);
    op_write(16'hFF00, 16'h7777, 1'b0);
    memread = 1'b1; addr = 16'h0030;
    @(negedge clk);
    reset = 1'b0;
    memread = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, ready}, 32'd0);
    chk("midrst_led", {16'h0, led}, 32'h0);
    chk("midrst_ram_we", {31'b0, ram_we}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_ready", {31'b0, ready}, 32'd0);
    end
    reset = 1'b1;
    ref_led = 16'h0000;
    ref_q.delete();
    ref_ovf = 1'b0;
    @(negedge clk);
    chk("postrst_ready", {31'b0, ready}, 32'd0);
    op_read(16'hFF02, "postrst_status");
    op_read(16'hFF00, "postrst_led");
    op_read(16'h0030, "postrst_ram");
    op_write(16'h0040, 16'h0BAD, 1'b0);

    // cycle counter
    txn(1'b1, 1'b0, 16'hFF03, 16'h0000, v1, lat);
    chk("cnt1_lat", lat, 32'd1);
    repeat (3) @(negedge clk);
    txn(1'b1, 1'b0, 16'hFF03, 16'h0000, v2, lat);
    chk("cnt2_lat", lat, 32'd1);
`ifdef MEM_RESPONDER_CYCLECNT_EN
    chk("cnt_delta", {16'h0, 16'(v2 - v1)}, 32'd5);
`else
    chk("cnt1_zero", {16'h0, v1}, 32'h0);
    chk("cnt2_zero", {16'h0, v2}, 32'h0);
`endif

    chk("ram_we_mmio", bad_we, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
